// File: rtl/mem_axi_rr_bridge.sv
// ---------------------------------------------------------------------------
// mem_axi_rr_bridge
//
// Shares one AXI4 master port between NumPorts TCDM-style requesters.
// A round-robin arbiter grants one requester at a time. Each granted request
// becomes a single-beat AXI transaction. Only one transaction is outstanding
// at any time, so responses are routed back to the port that was granted.
//
// Package mem_axi_pkg (below) holds the default AXI struct types
// bus_req_t / bus_resp_t (64-bit address, 64-bit data, 8-bit ID).
//
// Ports:
//   clk_i           clock, rising edge
//   rst_ni          asynchronous active-low reset
//   tcdm_req_i      per-port request
//   tcdm_gnt_o      per-port grant (onehot or zero, combinational, IDLE only)
//   tcdm_add_i      per-port byte address
//   tcdm_we_i       per-port write enable (1 = write, 0 = read)
//   tcdm_be_i       per-port byte enables for writes
//   tcdm_wdata_i    per-port write data
//   tcdm_r_valid_o  per-port one-cycle completion pulse (read or write)
//   tcdm_r_data_o   read data, shared by all ports, qualified by r_valid
//   tcdm_err_o      error flag (SLVERR/DECERR), qualified by r_valid
//   axi_req_o       AXI master request bundle
//   axi_resp_i      AXI slave response bundle
//   busy_o          high whenever the FSM is not in IDLE
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high. Once raised, a valid holds its payload stable until that
// edge. Ready may be driven independently of valid. A reset is the only
// event that removes a valid early.
// ---------------------------------------------------------------------------

package mem_axi_pkg;

   typedef struct packed {
      logic [7:0]  id;
      logic [63:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic        lock;
      logic [3:0]  cache;
      logic [2:0]  prot;
      logic [3:0]  qos;
      logic [3:0]  region;
      logic [5:0]  atop;
      logic [0:0]  user;
   } aw_chan_t;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  strb;
      logic        last;
      logic [0:0]  user;
   } w_chan_t;

   typedef struct packed {
      logic [7:0] id;
      logic [1:0] resp;
      logic [0:0] user;
   } b_chan_t;

   typedef struct packed {
      logic [7:0]  id;
      logic [63:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic        lock;
      logic [3:0]  cache;
      logic [2:0]  prot;
      logic [3:0]  qos;
      logic [3:0]  region;
      logic [0:0]  user;
   } ar_chan_t;

   typedef struct packed {
      logic [7:0]  id;
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
      logic [0:0]  user;
   } r_chan_t;

   typedef struct packed {
      aw_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ar_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } bus_req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    ar_ready;
      logic    w_ready;
      logic    b_valid;
      b_chan_t b;
      logic    r_valid;
      r_chan_t r;
   } bus_resp_t;

endpackage

module mem_axi_rr_bridge #(
   parameter int unsigned NumPorts  = 2,
   parameter int unsigned AddrWidth = 64,
   parameter int unsigned DataWidth = 64,
   parameter int unsigned IdWidth   = 8,
   parameter type axi_req_t  = mem_axi_pkg::bus_req_t,
   parameter type axi_resp_t = mem_axi_pkg::bus_resp_t
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic [NumPorts-1:0]                    tcdm_req_i,
   output logic [NumPorts-1:0]                    tcdm_gnt_o,
   input  logic [NumPorts-1:0][AddrWidth-1:0]     tcdm_add_i,
   input  logic [NumPorts-1:0]                    tcdm_we_i,
   input  logic [NumPorts-1:0][DataWidth/8-1:0]   tcdm_be_i,
   input  logic [NumPorts-1:0][DataWidth-1:0]     tcdm_wdata_i,
   output logic [NumPorts-1:0]                    tcdm_r_valid_o,
   output logic [DataWidth-1:0]                   tcdm_r_data_o,
   output logic                                   tcdm_err_o,
   output axi_req_t                               axi_req_o,
   input  axi_resp_t                              axi_resp_i,
   output logic                                   busy_o
);

   localparam int unsigned PtrW   = (NumPorts > 1) ? $clog2(NumPorts) : 1;
   localparam int unsigned BeW    = DataWidth / 8;
   localparam logic [2:0]  AxSize = 3'($clog2(BeW));

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WR   = 3'd1,
      WB   = 3'd2,
      RD   = 3'd3,
      RR   = 3'd4
   } state_e;

   state_e                state_q;
   logic [PtrW-1:0]       prio_q;
   logic [PtrW-1:0]       owner_q;
   logic [AddrWidth-1:0]  addr_q;
   logic [BeW-1:0]        be_q;
   logic [DataWidth-1:0]  wdata_q;

   logic                  aw_valid_q;
   logic                  w_valid_q;
   logic                  aw_done_q;
   logic                  w_done_q;
   logic                  b_ready_q;
   logic                  ar_valid_q;
   logic                  r_ready_q;

   logic [NumPorts-1:0]   r_valid_q;
   logic [DataWidth-1:0]  r_data_q;
   logic                  err_q;

   // Arbiter: first requester at or above prio_q, else first requester
   // overall. Both passes scan upward from index 0 so the lowest index wins.
   logic [PtrW-1:0]       winner;
   logic                  found;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int i = 0; i < int'(NumPorts); i++) begin
         if (!found && tcdm_req_i[i] && (PtrW'(i) >= prio_q)) begin
            found  = 1'b1;
            winner = PtrW'(i);
         end
      end
      for (int i = 0; i < int'(NumPorts); i++) begin
         if (!found && tcdm_req_i[i]) begin
            found  = 1'b1;
            winner = PtrW'(i);
         end
      end
   end

   // Grant is combinational so the requester sees it in the same cycle the
   // FSM captures its request. Gated by reset so nothing is granted while
   // the bridge is held in reset.
   always_comb begin
      tcdm_gnt_o = '0;
      if ((state_q == IDLE) && found && rst_ni) begin
         tcdm_gnt_o[winner] = 1'b1;
      end
   end

   logic aw_hs;
   logic w_hs;

   assign aw_hs = aw_valid_q & axi_resp_i.aw_ready;
   assign w_hs  = w_valid_q  & axi_resp_i.w_ready;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         prio_q     <= '0;
         owner_q    <= '0;
         addr_q     <= '0;
         be_q       <= '0;
         wdata_q    <= '0;
         aw_valid_q <= 1'b0;
         w_valid_q  <= 1'b0;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
         b_ready_q  <= 1'b0;
         ar_valid_q <= 1'b0;
         r_ready_q  <= 1'b0;
         r_valid_q  <= '0;
         r_data_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         // Completion pulse lasts exactly one cycle.
         r_valid_q <= '0;
         unique case (state_q)
            IDLE: begin
               if (found) begin
                  owner_q <= winner;
                  addr_q  <= tcdm_add_i[winner];
                  be_q    <= tcdm_be_i[winner];
                  wdata_q <= tcdm_wdata_i[winner];
                  prio_q  <= (winner == PtrW'(NumPorts - 1)) ? '0 : winner + 1'b1;
                  if (tcdm_we_i[winner]) begin
                     state_q    <= WR;
                     aw_valid_q <= 1'b1;
                     w_valid_q  <= 1'b1;
                     aw_done_q  <= 1'b0;
                     w_done_q   <= 1'b0;
                  end else begin
                     state_q    <= RD;
                     ar_valid_q <= 1'b1;
                  end
               end
            end
            WR: begin
               // AW and W complete independently; leave once both are done,
               // including the case where both land on the same edge.
               if (aw_hs) begin
                  aw_valid_q <= 1'b0;
                  aw_done_q  <= 1'b1;
               end
               if (w_hs) begin
                  w_valid_q <= 1'b0;
                  w_done_q  <= 1'b1;
               end
               if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                  state_q   <= WB;
                  b_ready_q <= 1'b1;
               end
            end
            WB: begin
               if (axi_resp_i.b_valid) begin
                  state_q            <= IDLE;
                  b_ready_q          <= 1'b0;
                  r_valid_q[owner_q] <= 1'b1;
                  r_data_q           <= '0;
                  err_q              <= axi_resp_i.b.resp[1];
               end
            end
            RD: begin
               if (axi_resp_i.ar_ready) begin
                  state_q    <= RR;
                  ar_valid_q <= 1'b0;
                  r_ready_q  <= 1'b1;
               end
            end
            RR: begin
               if (axi_resp_i.r_valid) begin
                  state_q            <= IDLE;
                  r_ready_q          <= 1'b0;
                  r_valid_q[owner_q] <= 1'b1;
                  r_data_q           <= axi_resp_i.r.data;
                  err_q              <= axi_resp_i.r.resp[1];
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy_o         = (state_q != IDLE);
   assign tcdm_r_valid_o = r_valid_q;
   assign tcdm_r_data_o  = r_data_q;
   assign tcdm_err_o     = err_q;

   // Request bundle: payload fields come straight from the captured request;
   // everything not listed stays zero.
   always_comb begin
      axi_req_o          = '0;

      axi_req_o.aw.id    = IdWidth'(owner_q);
      axi_req_o.aw.addr  = addr_q;
      axi_req_o.aw.len   = 8'd0;
      axi_req_o.aw.size  = AxSize;
      axi_req_o.aw.burst = 2'b01;
      axi_req_o.aw_valid = aw_valid_q;

      axi_req_o.w.data   = wdata_q;
      axi_req_o.w.strb   = be_q;
      axi_req_o.w.last   = 1'b1;
      axi_req_o.w_valid  = w_valid_q;

      axi_req_o.b_ready  = b_ready_q;

      axi_req_o.ar.id    = IdWidth'(owner_q);
      axi_req_o.ar.addr  = addr_q;
      axi_req_o.ar.len   = 8'd0;
      axi_req_o.ar.size  = AxSize;
      axi_req_o.ar.burst = 2'b01;
      axi_req_o.ar_valid = ar_valid_q;

      axi_req_o.r_ready  = r_ready_q;
   end

endmodule
